// File: rtl/edfic_pkg.sv
// Shared types and helpers for the EDF interrupt nesting controller.
// Holds the handshake state encoding and the wrap-safe deadline comparison.
package edfic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        CLAIM,
        SETTLE
    } nest_state_e;

    localparam int unsigned MaxDlW = 64;

    // Operands are zero-extended by the caller; only the low w bits of the
    // difference matter, so the result is the sign of (a - b) mod 2^w.
    function automatic logic earlier_than(input logic [MaxDlW-1:0] a,
                                          input logic [MaxDlW-1:0] b,
                                          input int unsigned       w);
        logic [MaxDlW-1:0] diff;
        diff = a - b;
        return diff[6'(w - 1)];
    endfunction

endpackage

// File: rtl/edfic_dl_stack.sv
// LIFO of absolute deadlines for nested in-service interrupts.
// Supports push, pop and a combined pop+push that replaces the top entry.
module edfic_dl_stack
    import edfic_pkg::*;
#(
    parameter  int unsigned Depth   = 4,
    parameter  int unsigned DlWidth = 24,
    localparam int unsigned DepthW  = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [DlWidth-1:0] data_i,
    output logic [DlWidth-1:0] top_o,
    output logic [DepthW-1:0]  depth_o,
    output logic               empty_o,
    output logic               full_o
);

    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [DlWidth-1:0] mem [Depth];
    logic [DepthW-1:0]  count_q;
    logic [DepthW-1:0]  top_ptr;
    logic [DepthW-1:0]  wr_ptr;
    logic               do_pop;
    logic               do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DepthW'(Depth));
    assign depth_o = count_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign top_ptr = count_q - DepthW'(1);
    // A simultaneous pop+push overwrites the current top slot.
    assign wr_ptr  = do_pop ? top_ptr : count_q;

    assign top_o = empty_o ? '0 : mem[top_ptr[AddrW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + DepthW'(do_push) - DepthW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AddrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/edfic_nest_ctrl.sv
// Claim/complete sequencer between the EDF controller and one hart.
// Offers the arbitration winner only when it pre-empts the running handler.
module edfic_nest_ctrl
    import edfic_pkg::*;
#(
    parameter  int unsigned NrIrqs  = 4,
    parameter  int unsigned DlWidth = 24,
    parameter  int unsigned Depth   = 4,
    localparam int unsigned IdWidth = $clog2(NrIrqs),
    localparam int unsigned DepthW  = $clog2(Depth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               arb_valid_i,
    input  logic [IdWidth-1:0] arb_id_i,
    input  logic [DlWidth-1:0] arb_dl_i,
    input  logic [DlWidth-1:0] mtime_i,
    output logic               edfic_ack_o,
    output logic [IdWidth-1:0] edfic_id_o,
    output logic               irq_o,
    output logic [IdWidth-1:0] irq_id_o,
    input  logic               irq_ack_i,
    input  logic               cmpl_i,
    output logic [DepthW-1:0]  depth_o,
    output logic [DlWidth-1:0] cur_dl_o,
    output logic               err_o
);

    nest_state_e        state_q, state_d;
    logic [IdWidth-1:0] id_q;
    logic [DlWidth-1:0] dl_q;
    logic [DlWidth-1:0] cand;
    logic [DlWidth-1:0] top_dl;
    logic               empty, full;
    logic               eligible;
    logic               latch;
    logic               push;
    logic               err_q;

    assign cand     = arb_dl_i + mtime_i;
    assign eligible = arb_valid_i & ~full &
                      (empty | earlier_than(MaxDlW'(cand), MaxDlW'(top_dl), DlWidth));

    edfic_dl_stack #(
        .Depth   (Depth),
        .DlWidth (DlWidth)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (cmpl_i),
        .data_i  (dl_q),
        .top_o   (top_dl),
        .depth_o (depth_o),
        .empty_o (empty),
        .full_o  (full)
    );

    always_comb begin
        state_d     = state_q;
        latch       = 1'b0;
        push        = 1'b0;
        irq_o       = 1'b0;
        edfic_ack_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    latch   = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                irq_o = 1'b1;
                if (irq_ack_i) begin
                    push    = 1'b1;
                    state_d = CLAIM;
                end else if (!arb_valid_i || arb_id_i != id_q) begin
                    state_d = IDLE;
                end
            end
            CLAIM: begin
                edfic_ack_o = 1'b1;
                state_d     = SETTLE;
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                id_q <= arb_id_i;
            end
            err_q <= err_q | (irq_ack_i & (state_q != OFFER)) | (cmpl_i & empty);
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch) begin
            dl_q <= cand;
        end
    end

    assign irq_id_o   = irq_o ? id_q : '0;
    assign edfic_id_o = id_q;
    assign cur_dl_o   = top_dl;
    assign err_o      = err_q;

endmodule

// File: tb/tb_edfic_nest_ctrl.sv
// Directed bench for edfic_nest_ctrl; claimed ids are scoreboarded against
// the controller claim strobe, everything else checked with direct assertions.
module tb_edfic_nest_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        arb_valid_i;
    logic [1:0]  arb_id_i;
    logic [23:0] arb_dl_i;
    logic [23:0] mtime_i;
    logic        edfic_ack_o;
    logic [1:0]  edfic_id_o;
    logic        irq_o;
    logic [1:0]  irq_id_o;
    logic        irq_ack_i;
    logic        cmpl_i;
    logic [2:0]  depth_o;
    logic [23:0] cur_dl_o;
    logic        err_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [1:0] sb_q[$];

    edfic_nest_ctrl #(.NrIrqs(4), .DlWidth(24), .Depth(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .arb_valid_i (arb_valid_i),
        .arb_id_i    (arb_id_i),
        .arb_dl_i    (arb_dl_i),
        .mtime_i     (mtime_i),
        .edfic_ack_o (edfic_ack_o),
        .edfic_id_o  (edfic_id_o),
        .irq_o       (irq_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i),
        .cmpl_i      (cmpl_i),
        .depth_o     (depth_o),
        .cur_dl_o    (cur_dl_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later and retire any claim strobe.
    task automatic step();
        logic [1:0] exp_id;
        @(posedge clk_i);
        #1;
        if (edfic_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_claim", 32'(edfic_ack_o), 32'd0);
            end else begin
                exp_id = sb_q.pop_front();
                check("claim_id", 32'(edfic_id_o), 32'(exp_id));
            end
        end
    endtask

    task automatic do_claim(input logic [1:0] id, input logic [23:0] dl, input logic [23:0] mt,
                            input logic [2:0] exp_depth, input logic [23:0] exp_top);
        arb_valid_i = 1'b1;
        arb_id_i    = id;
        arb_dl_i    = dl;
        mtime_i     = mt;
        step();
        check("offer_irq", 32'(irq_o), 32'd1);
        check("offer_id", 32'(irq_id_o), 32'(id));
        irq_ack_i = 1'b1;
        sb_q.push_back(id);
        step();
        check("claim_ack", 32'(edfic_ack_o), 32'd1);
        check("claim_depth", 32'(depth_o), 32'(exp_depth));
        check("claim_top", 32'(cur_dl_o), 32'(exp_top));
        check("claim_irq_low", 32'(irq_o), 32'd0);
        irq_ack_i   = 1'b0;
        arb_valid_i = 1'b0;
        step();
        check("settle_irq_low", 32'(irq_o), 32'd0);
        check("settle_ack_low", 32'(edfic_ack_o), 32'd0);
        step();
    endtask

    task automatic complete();
        cmpl_i = 1'b1;
        step();
        cmpl_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; arb_valid_i = 1'b0; arb_id_i = '0; arb_dl_i = '0;
        mtime_i = '0; irq_ack_i = 1'b0; cmpl_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_ack", 32'(edfic_ack_o), 32'd0);
        check("rst_depth", 32'(depth_o), 32'd0);
        check("rst_top", 32'(cur_dl_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // Basic claim: 100 + 50 = 150
        do_claim(2'd2, 24'd50, 24'd100, 3'd1, 24'd150);

        // Later candidate (170) must not pre-empt 150
        arb_valid_i = 1'b1; arb_id_i = 2'd1; arb_dl_i = 24'd60; mtime_i = 24'd110;
        step();
        step();
        check("no_preempt_irq", 32'(irq_o), 32'd0);
        do_claim(2'd1, 24'd20, 24'd110, 3'd2, 24'd130);
        complete();
        complete();
        check("drain_depth", 32'(depth_o), 32'd0);

        // Wrap-around: top 0xFFFFF0, cand 0x000010 is later
        do_claim(2'd0, 24'hFFFFF0, 24'd0, 3'd1, 24'hFFFFF0);
        arb_valid_i = 1'b1; arb_id_i = 2'd3; arb_dl_i = 24'd0; mtime_i = 24'h000010;
        step();
        step();
        check("wrap_no_offer", 32'(irq_o), 32'd0);
        arb_valid_i = 1'b0;
        complete();
        do_claim(2'd0, 24'h000010, 24'd0, 3'd1, 24'h000010);
        do_claim(2'd3, 24'hFFFFE0, 24'h000010, 3'd2, 24'hFFFFF0);
        complete();
        complete();

        // Withdraw on id change, then re-offer the new winner
        arb_valid_i = 1'b1; arb_id_i = 2'd2; arb_dl_i = 24'd50; mtime_i = 24'd0;
        step();
        check("wd_offer", 32'(irq_id_o), 32'd2);
        arb_id_i = 2'd3;
        step();
        check("wd_withdrawn", 32'(irq_o), 32'd0);
        step();
        check("wd_reoffer_irq", 32'(irq_o), 32'd1);
        check("wd_reoffer_id", 32'(irq_id_o), 32'd3);
        irq_ack_i = 1'b1;
        sb_q.push_back(2'd3);
        step();
        check("wd_depth", 32'(depth_o), 32'd1);
        check("wd_top", 32'(cur_dl_o), 32'd50);
        irq_ack_i = 1'b0; arb_valid_i = 1'b0;
        step();
        step();

        // Fill to Depth, then a still-earlier winner is not offered
        do_claim(2'd1, 24'd40, 24'd0, 3'd2, 24'd40);
        do_claim(2'd2, 24'd30, 24'd0, 3'd3, 24'd30);
        do_claim(2'd0, 24'd20, 24'd0, 3'd4, 24'd20);
        arb_valid_i = 1'b1; arb_id_i = 2'd1; arb_dl_i = 24'd10;
        step();
        step();
        check("full_no_offer", 32'(irq_o), 32'd0);
        check("full_depth", 32'(depth_o), 32'd4);
        arb_valid_i = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            complete();
            check("pop_depth", 32'(depth_o), 32'(i));
        end
        check("pop_no_err", 32'(err_o), 32'd0);
        complete();
        check("underflow_depth", 32'(depth_o), 32'd0);
        check("underflow_err", 32'(err_o), 32'd1);

        // Stray ack outside OFFER raises the sticky error
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst2_err", 32'(err_o), 32'd0);
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
        check("stray_ack_err", 32'(err_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;

        // Pop and push in the same OFFER cycle replace the top
        do_claim(2'd2, 24'd100, 24'd0, 3'd1, 24'd100);
        arb_valid_i = 1'b1; arb_id_i = 2'd1; arb_dl_i = 24'd80;
        step();
        check("sim_offer", 32'(irq_o), 32'd1);
        irq_ack_i = 1'b1; cmpl_i = 1'b1;
        sb_q.push_back(2'd1);
        step();
        check("sim_depth", 32'(depth_o), 32'd1);
        check("sim_top", 32'(cur_dl_o), 32'd80);
        check("sim_ack", 32'(edfic_ack_o), 32'd1);
        irq_ack_i = 1'b0; cmpl_i = 1'b0; arb_valid_i = 1'b0;

        // Reset while in CLAIM
        rst_i = 1'b1;
        step();
        check("rstc_ack", 32'(edfic_ack_o), 32'd0);
        check("rstc_id", 32'(edfic_id_o), 32'd0);
        check("rstc_irq", 32'(irq_o), 32'd0);
        check("rstc_depth", 32'(depth_o), 32'd0);
        check("rstc_top", 32'(cur_dl_o), 32'd0);
        check("rstc_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        step();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
